// File: rtl/uart_to_spi_bridge.sv
// ============================================================================
//  Module   : uart_to_spi_bridge
//  Purpose  : Receives 8N1 UART bytes and re-sends each one as an 8-bit
//             SPI mode-0 write (MSB first). Write-only, no flow control.
//  Options  : `define UART_FRAMING_CHECK_EN to drop bytes with a bad stop bit
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_to_spi_bridge #(
    parameter int CLKS_PER_BIT    = 10416,
    parameter int SPI_HALF_PERIOD = 50
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    output logic sclk,
    output logic mosi,
    output logic cs_n,
    output logic done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam int SPI_W = $clog2(SPI_HALF_PERIOD + 1);
    localparam logic [CNT_W-1:0] C_HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] C_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [SPI_W-1:0] C_SPI_LAST  = SPI_W'(SPI_HALF_PERIOD - 1);

    typedef enum logic [2:0] {
        U_IDLE    = 3'd0,
        U_START   = 3'd1,
        U_DATA    = 3'd2,
        U_STOP    = 3'd3,
        U_RECOVER = 3'd4   // waits for line idle after a framing error
    } uart_state_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_FINISH = 2'd2
    } spi_state_t;

    logic             rx_meta_q, rx_sync_q;
    uart_state_t      ustate_q;
    logic [CNT_W-1:0] ucnt_q;
    logic [2:0]       ubit_q;
    logic [7:0]       rxsh_q;
    logic [7:0]       rx_byte_q;
    logic             rx_valid_q;

    spi_state_t       sstate_q;
    logic             pend_q;
    logic [7:0]       pend_byte_q;
    logic [7:0]       sh_q;
    logic [SPI_W-1:0] hcnt_q;
    logic [3:0]       edge_q;
    logic             sclk_q, mosi_q, cs_n_q, done_q;

    // Two-flop synchronizer for the asynchronous serial line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // UART receiver: mid-bit sampling, LSB first, one-cycle valid on completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ustate_q   <= U_IDLE;
            ucnt_q     <= '0;
            ubit_q     <= '0;
            rxsh_q     <= '0;
            rx_byte_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            case (ustate_q)
                U_IDLE: begin
                    ucnt_q <= '0;
                    if (!rx_sync_q) ustate_q <= U_START;
                end
                U_START: begin
                    if (ucnt_q == C_HALF_LAST) begin
                        ucnt_q   <= '0;
                        ubit_q   <= '0;
                        // A line already back high mid-start-bit is a glitch
                        ustate_q <= rx_sync_q ? U_IDLE : U_DATA;
                    end else begin
                        ucnt_q <= ucnt_q + 1'b1;
                    end
                end
                U_DATA: begin
                    if (ucnt_q == C_BIT_LAST) begin
                        ucnt_q <= '0;
                        rxsh_q <= {rx_sync_q, rxsh_q[7:1]};
                        ubit_q <= ubit_q + 1'b1;
                        if (ubit_q == 3'd7) ustate_q <= U_STOP;
                    end else begin
                        ucnt_q <= ucnt_q + 1'b1;
                    end
                end
                U_STOP: begin
                    if (ucnt_q == C_BIT_LAST) begin
                        ucnt_q <= '0;
`ifdef UART_FRAMING_CHECK_EN
                        if (rx_sync_q) begin
                            rx_byte_q  <= rxsh_q;
                            rx_valid_q <= 1'b1;
                            ustate_q   <= U_IDLE;
                        end else begin
                            ustate_q   <= U_RECOVER;
                        end
`else
                        rx_byte_q  <= rxsh_q;
                        rx_valid_q <= 1'b1;
                        ustate_q   <= U_IDLE;
`endif
                    end else begin
                        ucnt_q <= ucnt_q + 1'b1;
                    end
                end
                U_RECOVER: begin
                    if (rx_sync_q) ustate_q <= U_IDLE;
                end
                default: ustate_q <= U_IDLE;
            endcase
        end
    end

    // SPI master plus pending-byte holding register (newest byte wins)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sstate_q    <= S_IDLE;
            pend_q      <= 1'b0;
            pend_byte_q <= '0;
            sh_q        <= '0;
            hcnt_q      <= '0;
            edge_q      <= '0;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            cs_n_q      <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (sstate_q)
                S_IDLE: begin
                    if (pend_q) begin
                        sh_q     <= pend_byte_q;
                        mosi_q   <= pend_byte_q[7];
                        cs_n_q   <= 1'b0;
                        hcnt_q   <= '0;
                        edge_q   <= '0;
                        sstate_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (hcnt_q == C_SPI_LAST) begin
                        hcnt_q <= '0;
                        sclk_q <= ~sclk_q;
                        edge_q <= edge_q + 1'b1;
                        // Falling edge (sclk currently high): present next bit,
                        // except on the final falling edge which ends the frame
                        if (sclk_q && (edge_q != 4'd15)) begin
                            sh_q   <= {sh_q[6:0], 1'b0};
                            mosi_q <= sh_q[6];
                        end
                        if (edge_q == 4'd15) sstate_q <= S_FINISH;
                    end else begin
                        hcnt_q <= hcnt_q + 1'b1;
                    end
                end
                S_FINISH: begin
                    cs_n_q   <= 1'b1;
                    sclk_q   <= 1'b0;
                    mosi_q   <= 1'b0;
                    done_q   <= 1'b1;
                    sstate_q <= S_IDLE;
                end
                default: sstate_q <= S_IDLE;
            endcase

            // A freshly received byte takes priority over the consume-clear
            if (rx_valid_q) begin
                pend_q      <= 1'b1;
                pend_byte_q <= rx_byte_q;
            end else if ((sstate_q == S_IDLE) && pend_q) begin
                pend_q <= 1'b0;
            end
        end
    end

    assign sclk = sclk_q;
    assign mosi = mosi_q;
    assign cs_n = cs_n_q;
    assign done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_to_spi_bridge.sv
// ============================================================================
//  Module   : tb_uart_to_spi_bridge
//  Purpose  : Directed self-checking bench for uart_to_spi_bridge, using
//             shortened bit / SCLK timing.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_to_spi_bridge;

    localparam int CPB  = 16;
    localparam int HALF = 4;
    localparam int WIN  = 16 * HALF + 1;   // cycles cs_n is sampled low

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rx    = 1'b1;
    logic sclk, mosi, cs_n, done;

    int total = 0;
    int bad   = 0;

    uart_to_spi_bridge #(
        .CLKS_PER_BIT    (CPB),
        .SPI_HALF_PERIOD (HALF)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (rx),
        .sclk  (sclk),
        .mosi  (mosi),
        .cs_n  (cs_n),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Bus monitor: captures mosi at each sclk rise, cs_n window length,
    // and logs one record per done pulse
    logic       cs_prev   = 1'b1;
    logic       sclk_prev = 1'b0;
    int         cs_falls  = 0;
    int         rises     = 0;
    int         win       = 0;
    int         done_cnt  = 0;
    logic [7:0] cap       = 8'h00;
    logic [7:0] q_byte[$];
    int         q_rise[$];
    int         q_win[$];

    always @(negedge clk) begin
        cs_prev   <= cs_n;
        sclk_prev <= sclk;
        if (cs_prev && !cs_n) begin
            cs_falls <= cs_falls + 1;
            rises    <= 0;
            win      <= 1;
            cap      <= 8'h00;
        end else if (!cs_n) begin
            win <= win + 1;
        end
        if (sclk && !sclk_prev) begin
            cap   <= {cap[6:0], mosi};
            rises <= rises + 1;
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            q_byte.push_back(cap);
            q_rise.push_back(rises);
            q_win.push_back(win);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic uart_send(input logic [7:0] b, input logic stop_bit);
        @(negedge clk) rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic wait_done(input string tag, input int target);
        for (int i = 0; i < 2000 && done_cnt < target; i++) @(negedge clk);
        check(tag, done_cnt, target);
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp_b);
        if (q_byte.size() > 0) begin
            check({tag, "_byte"}, q_byte.pop_front(), exp_b);
            check({tag, "_rises"}, q_rise.pop_front(), 8);
            check({tag, "_win"}, q_win.pop_front(), WIN);
        end else begin
            check({tag, "_record"}, 0, 1);
        end
    endtask

    int falls_snap;
    int done_snap;

    initial begin
        // Reset with idle line
        repeat (3) @(negedge clk);
        check("rst_sclk", sclk, 1'b0);
        check("rst_mosi", mosi, 1'b0);
        check("rst_cs_n", cs_n, 1'b1);
        check("rst_done", done, 1'b0);
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        check("idle_cs_falls", cs_falls, 0);
        check("idle_done", done_cnt, 0);

        // Single byte 0xAA -> mosi 1,0,1,0,1,0,1,0 at rises
        uart_send(8'hAA, 1'b1);
        wait_done("aa_done", 1);
        pop_check("aa", 8'hAA);
        repeat (100) @(negedge clk);
        check("aa_single_pulse", done_cnt, 1);
        check("aa_one_window", cs_falls, 1);

        // Back-to-back 0x01, 0xFF
        uart_send(8'h01, 1'b1);
        uart_send(8'hFF, 1'b1);
        wait_done("b2b_done", 3);
        pop_check("b2b_01", 8'h01);
        pop_check("b2b_ff", 8'hFF);

        // Short low pulse on rx is rejected as a glitch
        falls_snap = cs_falls;
        @(negedge clk) rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        repeat (400) @(negedge clk);
        check("glitch_cs_falls", cs_falls, falls_snap);
        check("glitch_done", done_cnt, 3);

        // 0x5A with a zero stop bit
        uart_send(8'h5A, 1'b0);
`ifdef UART_FRAMING_CHECK_EN
        repeat (400) @(negedge clk);
        check("frm_dropped", done_cnt, 3);
`else
        wait_done("frm_done", 4);
        pop_check("frm_5a", 8'h5A);
`endif
        repeat (50) @(negedge clk);
        done_snap = done_cnt;

        // Reset pulse in the middle of an SPI transfer
        uart_send(8'h3C, 1'b1);
        for (int i = 0; i < 200 && cs_n; i++) @(negedge clk);
        check("mid_cs_low", cs_n, 1'b0);
        repeat (20) @(negedge clk);
        #3 rst_n = 1'b0;
        #5;
        check("mid_rst_sclk", sclk, 1'b0);
        check("mid_rst_mosi", mosi, 1'b0);
        check("mid_rst_cs_n", cs_n, 1'b1);
        check("mid_rst_done", done, 1'b0);
        #15 rst_n = 1'b1;
        repeat (300) @(negedge clk);
        check("mid_no_done", done_cnt, done_snap);

        // Next byte after the abort transfers normally
        uart_send(8'hC3, 1'b1);
        wait_done("post_done", done_snap + 1);
        pop_check("post_c3", 8'hC3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
